fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 Parameter INSTR_W, default 16, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-4].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  8  instruction-memory word address.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  INSTR_W  fetched instruction word.
REQ-009 instr_valid  output  1  instr/instr_pc hold a valid instruction for decode.
REQ-010 instr_ready  input  1  decode/control stage accepts the instruction.
REQ-011 instr  output  INSTR_W  instruction to decode; opcode field drives the control unit.
REQ-012 instr_pc  output  8  address the presented instruction was fetched from.
REQ-013 redirect  input  1  one-cycle pulse: taken JMP/JZ from execute.
REQ-014 redirect_pc  input  8  branch target, valid when redirect=1.
REQ-015 pc  output  8  address of the next fetch.

Function
REQ-016 States: IDLE, REQ, HOLD, DRAIN; encoding is implementation choice.
REQ-017 IDLE: imem_req=0; unconditional transition to REQ next cycle.
REQ-018 REQ: imem_req=1, imem_addr=pc; imem_addr stays stable until imem_ack.
REQ-019 REQ with imem_ack, no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, go HOLD.
REQ-020 HOLD: instr_valid=1, instr/instr_pc stable, imem_req=0; on instr_ready=1, instr_valid<=0, go REQ.
REQ-021 Fetch-to-valid latency: instr_valid rises the cycle after imem_ack; zero-wait memory gives one instruction per 2 cycles.
REQ-022 PC arithmetic is modulo 256: pc 8'hFF increments to 8'h00, no flag.
REQ-023 Redirect in REQ without imem_ack: pc<=redirect_pc, go DRAIN; imem_req/imem_addr keep the old request.
REQ-024 DRAIN: imem_req=1, imem_addr=old address; on imem_ack discard imem_rdata (instr, instr_valid unchanged), go REQ.
REQ-025 Redirect in REQ coincident with imem_ack: discard imem_rdata, pc<=redirect_pc, instr_valid stays 0, go REQ.
REQ-026 Redirect in HOLD: instr_valid<=0, pc<=redirect_pc, go REQ; if instr_ready was also 1, that instruction counts as consumed.
REQ-027 Redirect in IDLE: pc<=redirect_pc, go REQ.
REQ-028 Redirect in DRAIN: pc<=redirect_pc (latest wins); stay in DRAIN until imem_ack.
REQ-029 Redirect always takes priority over pc+1.
REQ-030 instr_valid never rises for data returned by a request issued before a redirect.
REQ-031 imem_ack outside REQ/DRAIN is ignored.

Reset
REQ-032 Reset forces: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-033 Reset mid-request abandons the outstanding fetch; a late imem_ack after reset release is ignored in IDLE, and the first REQ after reset fetches RESET_PC.

Verification
REQ-034 Reset release, zero-wait memory returns 16'h1234 @0, 16'h5678 @1, instr_ready=1 -> instr_valid pulses with instr_pc 0 then 1, one instruction per 2 cycles.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc stable, imem_req=0 throughout, no pc change.
REQ-036 Memory with 3-cycle ack latency at pc=4, redirect to 8'h20 in first wait cycle -> addr 4 held until ack, data discarded, next request addr 8'h20, first valid instr_pc=8'h20.
REQ-037 Redirect to 8'h40 coincident with imem_ack -> no instr_valid for that data, next imem_addr=8'h40.
REQ-038 Sequential fetch from pc=8'hFF -> instr_pc=8'hFF, next imem_addr=8'h00.
REQ-039 Reset asserted during DRAIN with late imem_ack one cycle after release -> no instr_valid, first fetch address RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, decode handoff and branch redirect.
// The master modport is the fetch unit; the slave modport is the memory/decode/execute side.
interface fetch_unit_if #(
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [7:0]         imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [7:0]         instr_pc;
  logic               redirect;
  logic [7:0]         redirect_pc;
  logic [7:0]         pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, single-entry decode buffer,
// branch redirect with drain of in-flight requests issued before the redirect.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned INSTR_W  = 16
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         pc_q, pc_d;
  logic [7:0]         addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.redirect) pc_d = bus.redirect_pc;
        state_d = REQ;
      end
      REQ: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = bus.imem_ack ? REQ : DRAIN;
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 8'd1;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (bus.redirect) pc_d = bus.redirect_pc;
        if (bus.imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // The request address is frozen while draining; otherwise it tracks the next pc
    // so that every entry into REQ presents the address being fetched.
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  assign bus.imem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for slow memory with redirect and reset during a drain.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.INSTR_W(16)) bus ();

  fetch_unit #(
    .RESET_PC (8'h00),
    .INSTR_W  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic [7:0]  rpc;
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        req;
    logic [7:0]  addr;
    logic        vld;
    logic [15:0] ins;
    logic [7:0]  ipc;
    logic [7:0]  pc;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // Drive this cycle's inputs, check the (registered) outputs, then advance one clock.
  task automatic step(input string tag, input int idx, input vec_t v);
    bus.redirect    = v.rd;
    bus.redirect_pc = v.rpc;
    bus.imem_ack    = v.ack;
    bus.imem_rdata  = v.rdata;
    bus.instr_ready = v.rdy;
    chk({tag, ".imem_req"},    idx, 16'(bus.imem_req),    16'(v.req));
    chk({tag, ".imem_addr"},   idx, 16'(bus.imem_addr),   16'(v.addr));
    chk({tag, ".instr_valid"}, idx, 16'(bus.instr_valid), 16'(v.vld));
    chk({tag, ".instr"},       idx, bus.instr,            v.ins);
    chk({tag, ".instr_pc"},    idx, 16'(bus.instr_pc),    16'(v.ipc));
    chk({tag, ".pc"},          idx, 16'(bus.pc),          16'(v.pc));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".imem_req"},    0, 16'(bus.imem_req),    16'h0);
    chk({tag, ".imem_addr"},   0, 16'(bus.imem_addr),   16'h00);
    chk({tag, ".instr_valid"}, 0, 16'(bus.instr_valid), 16'h0);
    chk({tag, ".instr"},       0, bus.instr,            16'h0000);
    chk({tag, ".instr_pc"},    0, 16'(bus.instr_pc),    16'h00);
    chk({tag, ".pc"},          0, 16'(bus.pc),          16'h00);
  endtask

  task automatic do_reset();
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
  endtask

  initial begin
    //            rd  rpc    ack rdata     rdy | req addr   vld ins       ipc    pc
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}; // IDLE
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}; // REQ @0, ack
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01, 1'b1, 16'h1234, 8'h00, 8'h01}; // HOLD, taken
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 16'h5678, 1'b0, 1'b1, 8'h01, 1'b0, 16'h1234, 8'h00, 8'h01}; // REQ @1, ack
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h02, 1'b1, 16'h5678, 8'h01, 8'h02}; // HOLD stall 1
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h02, 1'b1, 16'h5678, 8'h01, 8'h02}; // stray ack ignored
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h02, 1'b1, 16'h5678, 8'h01, 8'h02};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h02, 1'b1, 16'h5678, 8'h01, 8'h02};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h02, 1'b1, 16'h5678, 8'h01, 8'h02}; // stall 5
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h02, 1'b1, 16'h5678, 8'h01, 8'h02}; // taken
    tbl[10] = '{1'b1, 8'h40, 1'b1, 16'hDEAD, 1'b0, 1'b1, 8'h02, 1'b0, 16'h5678, 8'h01, 8'h02}; // redirect + ack
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h40, 1'b0, 16'h5678, 8'h01, 8'h40}; // redirect, no ack
    tbl[12] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h40, 1'b0, 16'h5678, 8'h01, 8'hFF}; // DRAIN wait
    tbl[13] = '{1'b0, 8'h00, 1'b1, 16'hBAD1, 1'b0, 1'b1, 8'h40, 1'b0, 16'h5678, 8'h01, 8'hFF}; // DRAIN ack dropped
    tbl[14] = '{1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0, 1'b1, 8'hFF, 1'b0, 16'h5678, 8'h01, 8'hFF}; // REQ @FF
    tbl[15] = '{1'b1, 8'h10, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 16'hABCD, 8'hFF, 8'h00}; // wrap, redirect in HOLD
    tbl[16] = '{1'b0, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b1, 8'h10, 1'b0, 16'hABCD, 8'hFF, 8'h10}; // REQ @10
    tbl[17] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h11, 1'b1, 16'h1111, 8'h10, 8'h11};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h11, 1'b0, 16'h1111, 8'h10, 8'h11};

    do_reset();
    for (int i = 0; i < 19; i++) step("tbl", i, tbl[i]);

    // Slow memory at pc=4 with redirect to 20 in the first wait cycle.
    do_reset();
    step("slow", 0, '{1'b1, 8'h04, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}); // IDLE redirect
    step("slow", 1, '{1'b1, 8'h20, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h04, 1'b0, 16'h0000, 8'h00, 8'h04}); // wait 1
    step("slow", 2, '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h04, 1'b0, 16'h0000, 8'h00, 8'h20}); // wait 2
    step("slow", 3, '{1'b0, 8'h00, 1'b1, 16'h0404, 1'b0, 1'b1, 8'h04, 1'b0, 16'h0000, 8'h00, 8'h20}); // late ack
    step("slow", 4, '{1'b0, 8'h00, 1'b1, 16'h2020, 1'b0, 1'b1, 8'h20, 1'b0, 16'h0000, 8'h00, 8'h20}); // REQ @20
    step("slow", 5, '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h21, 1'b1, 16'h2020, 8'h20, 8'h21});

    // Reset while draining, then a late ack one cycle after release.
    do_reset();
    step("rstdrain", 0, '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}); // IDLE
    step("rstdrain", 1, '{1'b1, 8'h30, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}); // -> DRAIN
    chk("rstdrain.in_drain_req", 0, 16'(bus.imem_req), 16'h1);
    chk("rstdrain.in_drain_pc",  0, 16'(bus.pc),       16'h30);
    reset = 1'b1;
    #1;
    check_reset_state("rstdrain.async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rstdrain", 2, '{1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}); // late ack in IDLE
    step("rstdrain", 3, '{1'b0, 8'h00, 1'b1, 16'h0A0A, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00}); // REQ @RESET_PC
    step("rstdrain", 4, '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01, 1'b1, 16'h0A0A, 8'h00, 8'h01});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
